seg_scan_axil: RTL and testbench



---
 rtl/seg_scan_axil.sv | 192 +++++++++++++++++++
 tb/tb_seg_scan_axil.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_axil.sv
// AXI4-Lite multiplexed seven-segment driver; pins update 1 cycle after a register write or digit step.
// One outstanding write and one outstanding read; B/R responses are held until BREADY/RREADY.
module seg_scan_axil #(
  parameter int NUM_DIGITS         = 8,
  parameter int SCAN_DIV           = 100000,
  parameter bit ACTIVE_LOW         = 1'b1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            i_core_clk,
  input  logic                            i_arst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_s_axi_awaddr,
  input  logic [2:0]                      i_s_axi_awprot,
  input  logic                            i_s_axi_awvalid,
  output logic                            o_s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   i_s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] i_s_axi_wstrb,
  input  logic                            i_s_axi_wvalid,
  output logic                            o_s_axi_wready,
  output logic [1:0]                      o_s_axi_bresp,
  output logic                            o_s_axi_bvalid,
  input  logic                            i_s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_s_axi_araddr,
  input  logic [2:0]                      i_s_axi_arprot,
  input  logic                            i_s_axi_arvalid,
  output logic                            o_s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   o_s_axi_rdata,
  output logic [1:0]                      o_s_axi_rresp,
  output logic                            o_s_axi_rvalid,
  input  logic                            i_s_axi_rready,
  output logic [6:0]                      o_seg,
  output logic                            o_dp,
  output logic [NUM_DIGITS-1:0]           o_an
);

  localparam int                    PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]         PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]            DIG_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};

  logic                          r_awready, r_bvalid, r_arready, r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [31:0]                   r_data;
  logic                          r_en, r_mode;
  logic [7:0]                    r_dp_mask, r_blank;
  logic [3:0]                    r_bright;
  logic [PW-1:0]                 r_pre;
  logic [2:0]                    r_digit;
  logic [3:0]                    r_phase;
  logic [7:0]                    r_frame;
  logic [NUM_DIGITS-1:0]         r_an;
  logic [6:0]                    r_seg;
  logic                          r_dp;

  logic                          w_wr, w_rd, w_lit;
  logic [31:0]                   w_rdata;
  logic [3:0]                    w_nib;
  logic [NUM_DIGITS-1:0]         w_onehot;
  logic                          w_unused;

  assign w_unused = ^{i_s_axi_awprot, i_s_axi_arprot, i_s_axi_awaddr[1:0], i_s_axi_araddr[1:0]};

  function automatic logic [6:0] f_decode(input logic [3:0] nib, input logic bcd);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
    if (bcd && nib > 4'd9) seg = 7'h40;
    return seg;
  endfunction

  assign w_wr = r_awready && i_s_axi_awvalid && i_s_axi_wvalid;
  assign w_rd = r_arready && i_s_axi_arvalid;

  always_comb begin
    w_rdata = 32'h0;
    case (i_s_axi_araddr[3:2])
      2'd0:    w_rdata = r_data;
      2'd1:    w_rdata = {8'h00, r_blank, r_dp_mask, 6'h00, r_mode, r_en};
      2'd2:    w_rdata = {28'h0, r_bright};
      default: w_rdata = {16'h0, r_frame, 5'h00, r_digit};
    endcase
  end

  // Ready is registered, so it rises the cycle after both valids and the handshake lands on the next edge.
  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_data    <= 32'h0;
      r_en      <= 1'b0;
      r_mode    <= 1'b0;
      r_dp_mask <= 8'h00;
      r_blank   <= 8'h00;
      r_bright  <= 4'hF;
    end else begin
      r_awready <= !r_awready && i_s_axi_awvalid && i_s_axi_wvalid && !r_bvalid;
      r_arready <= !r_arready && i_s_axi_arvalid && !r_rvalid;
      if (w_wr)                r_bvalid <= 1'b1;
      else if (i_s_axi_bready) r_bvalid <= 1'b0;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (i_s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
      if (w_wr) begin
        case (i_s_axi_awaddr[3:2])
          2'd0: begin
            for (int b = 0; b < 4; b++)
              if (i_s_axi_wstrb[b]) r_data[8*b +: 8] <= i_s_axi_wdata[8*b +: 8];
          end
          2'd1: begin
            if (i_s_axi_wstrb[0]) begin
              r_en   <= i_s_axi_wdata[0];
              r_mode <= i_s_axi_wdata[1];
            end
            if (i_s_axi_wstrb[1]) r_dp_mask <= i_s_axi_wdata[15:8];
            if (i_s_axi_wstrb[2]) r_blank   <= i_s_axi_wdata[23:16];
          end
          2'd2: if (i_s_axi_wstrb[0]) r_bright <= i_s_axi_wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  // Disabling parks the scan at digit 0, so re-enabling always starts a fresh frame.
  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_pre   <= '0;
      r_digit <= 3'd0;
      r_phase <= 4'd0;
      r_frame <= 8'd0;
    end else if (!r_en) begin
      r_pre   <= '0;
      r_digit <= 3'd0;
      r_phase <= 4'd0;
    end else begin
      r_phase <= r_phase + 4'd1;
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        if (r_digit == DIG_LAST) begin
          r_digit <= 3'd0;
          r_frame <= r_frame + 8'd1;
        end else begin
          r_digit <= r_digit + 3'd1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  always_comb begin
    w_nib = r_data[{r_digit, 2'b00} +: 4];
    w_lit = r_en && !r_blank[r_digit] && (r_phase <= r_bright);
    for (int i = 0; i < NUM_DIGITS; i++) w_onehot[i] = (3'(i) == r_digit);
  end

  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= ACTIVE_LOW;
    end else begin
      r_an  <= (w_lit ? w_onehot : '0) ^ AN_OFF;
      r_seg <= (w_lit ? f_decode(w_nib, r_mode) : 7'h00) ^ SEG_OFF;
      r_dp  <= (w_lit && r_dp_mask[r_digit]) ^ ACTIVE_LOW;
    end
  end

  assign o_s_axi_awready = r_awready;
  assign o_s_axi_wready  = r_awready;
  assign o_s_axi_bvalid  = r_bvalid;
  assign o_s_axi_bresp   = 2'b00;
  assign o_s_axi_arready = r_arready;
  assign o_s_axi_rvalid  = r_rvalid;
  assign o_s_axi_rdata   = r_rdata;
  assign o_s_axi_rresp   = 2'b00;
  assign o_an            = r_an;
  assign o_seg           = r_seg;
  assign o_dp            = r_dp;

endmodule

// File: tb/tb_seg_scan_axil.sv
// Scoreboard bench for seg_scan_axil: stimulus queues expected B/R responses and digit-slot patterns, a negedge monitor checks them.
module tb_seg_scan_axil;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  always #5 clk = ~clk;

  seg_scan_axil #(.NUM_DIGITS(8), .SCAN_DIV(16), .ACTIVE_LOW(1'b1),
                  .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .i_core_clk(clk), .i_arst_n(rst_n),
    .i_s_axi_awaddr(awaddr), .i_s_axi_awprot(awprot), .i_s_axi_awvalid(awvalid), .o_s_axi_awready(awready),
    .i_s_axi_wdata(wdata), .i_s_axi_wstrb(wstrb), .i_s_axi_wvalid(wvalid), .o_s_axi_wready(wready),
    .o_s_axi_bresp(bresp), .o_s_axi_bvalid(bvalid), .i_s_axi_bready(bready),
    .i_s_axi_araddr(araddr), .i_s_axi_arprot(arprot), .i_s_axi_arvalid(arvalid), .o_s_axi_arready(arready),
    .o_s_axi_rdata(rdata), .o_s_axi_rresp(rresp), .o_s_axi_rvalid(rvalid), .i_s_axi_rready(rready),
    .o_seg(seg), .o_dp(dp), .o_an(an)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    string       name;
  } rexp_t;

  int          tests = 0;
  int          fails = 0;
  rexp_t       exp_r[$];
  logic [1:0]  exp_b[$];
  logic [15:0] exp_d[$];
  rexp_t       cur_r;
  logic [7:0]  prev_an = 8'hFF;
  int          cyc = 0;
  int          win_lo = 0;
  int          win_hi = -1;
  int          lit_cnt[8];
  logic [6:0]  hex_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected pin pattern {an, seg, dp} for digit i lit with active-high segments/dp.
  function automatic logic [15:0] ev(input int i, input logic [6:0] seg_on, input logic dp_on);
    logic [7:0] one = 8'h01;
    return {~(one << i), ~seg_on, ~dp_on};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: BVALID with bresp %0d while no write was pending", bresp);
      end else begin
        check("bresp", {30'h0, bresp}, {30'h0, exp_b.pop_front()});
      end
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) begin
        tests++; fails++;
        $display("FAIL r_unexpected: RVALID with data 0x%0h while no read was pending", rdata);
      end else begin
        cur_r = exp_r.pop_front();
        check(cur_r.name, rdata & cur_r.mask, cur_r.data & cur_r.mask);
        check("rresp", {30'h0, rresp}, 32'h0);
      end
    end
    if (an != 8'hFF && an != prev_an && exp_d.size() > 0)
      check("disp_slot", {16'h0, an, seg, dp}, {16'h0, exp_d.pop_front()});
    prev_an = an;
    if (cyc == win_lo) foreach (lit_cnt[i]) lit_cnt[i] = 0;
    if (cyc >= win_lo && cyc <= win_hi)
      for (int i = 0; i < 8; i++) if (!an[i]) lit_cnt[i]++;
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input bit expect_b);
    bit seen = 1'b0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    if (expect_b) exp_b.push_back(2'b00);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = awready && wready;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL aw_timeout: no AWREADY/WREADY for addr 0x%0h", a);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic drain_axi();
    for (int k = 0; k < 20 && (exp_b.size() != 0 || exp_r.size() != 0); k++) @(negedge clk);
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      tests++; fails++;
      $display("FAIL axi_resp_timeout: %0d B and %0d R responses missing", exp_b.size(), exp_r.size());
      exp_b.delete(); exp_r.delete();
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] d, input logic [31:0] m, input string name);
    rexp_t e;
    bit seen = 1'b0;
    e.data = d; e.mask = m; e.name = name;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    exp_r.push_back(e);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = arready;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL ar_timeout: no ARREADY for %s", name);
    end
    @(negedge clk);
    arvalid = 1'b0;
    drain_axi();
  endtask

  task automatic drain_disp(input int budget);
    for (int k = 0; k < budget && exp_d.size() != 0; k++) @(negedge clk);
    if (exp_d.size() != 0) begin
      tests++; fails++;
      $display("FAIL disp_timeout: %0d digit slots not seen", exp_d.size());
      exp_d.delete();
    end
  endtask

  // Enable with the given CTRL and count lit cycles per digit over exactly the first frame.
  task automatic enable_frame(input logic [31:0] ctrl);
    wr(4'h4, ctrl, 4'hF, 1'b1);
    #1;
    win_lo = cyc + 1;
    win_hi = cyc + 128;
    drain_disp(200);
    for (int k = 0; k < 300 && cyc <= win_hi; k++) @(negedge clk);
    if (cyc <= win_hi) begin
      tests++; fails++;
      $display("FAIL window_timeout: count window still open at cycle %0d", cyc);
    end
    drain_axi();
  endtask

  task automatic check_lit(input string name, input logic [7:0] lit_mask, input int on_cnt);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_d%0d", name, i), lit_cnt[i], lit_mask[i] ? on_cnt : 0);
  endtask

  task automatic disable_disp();
    wr(4'h4, 32'h0, 4'hF, 1'b1);
    repeat (4) @(negedge clk);
    drain_axi();
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = 4'h0; araddr = 4'h0; awprot = 3'h0; arprot = 3'h0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", {24'h0, an}, 32'hFF);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_dp", {31'h0, dp}, 32'h1);
    check("rst_hs", {27'h0, awready, wready, bvalid, arready, rvalid}, 32'h0);
    rst_n = 1'b1;
    rd(4'h0, 32'h0, 32'hFFFF_FFFF, "rst_data");
    rd(4'h4, 32'h0, 32'hFFFF_FFFF, "rst_ctrl");
    rd(4'h8, 32'hF, 32'hFFFF_FFFF, "rst_bright");
    rd(4'hC, 32'h0, 32'hFFFF_FFFF, "rst_status");

    // Hex scan of 0..7, full brightness, frame counter after one frame
    wr(4'h0, 32'h7654_3210, 4'hF, 1'b1);
    for (int i = 0; i < 8; i++) exp_d.push_back(ev(i, hex_tab[i], 1'b0));
    enable_frame(32'h1);
    check_lit("hex_lit", 8'hFF, 16);
    rd(4'hC, 32'h0000_0100, 32'h0000_FF00, "frame_cnt");

    // BCD mode: 8, 9 decode; A..F show a dash
    disable_disp();
    wr(4'h0, 32'hFEDC_BA98, 4'hF, 1'b1);
    exp_d.push_back(ev(0, 7'h7F, 1'b0));
    exp_d.push_back(ev(1, 7'h6F, 1'b0));
    for (int i = 2; i < 8; i++) exp_d.push_back(ev(i, 7'h40, 1'b0));
    enable_frame(32'h3);

    // DP on digits 0-3, digits 4-7 blanked
    disable_disp();
    exp_d.push_back(ev(0, 7'h7F, 1'b1));
    exp_d.push_back(ev(1, 7'h6F, 1'b1));
    exp_d.push_back(ev(2, 7'h77, 1'b1));
    exp_d.push_back(ev(3, 7'h7C, 1'b1));
    enable_frame(32'h00F0_0F01);
    check_lit("blank_lit", 8'h0F, 16);

    // Brightness 3 then 0
    disable_disp();
    wr(4'h0, 32'h7654_3210, 4'hF, 1'b1);
    wr(4'h8, 32'h3, 4'hF, 1'b1);
    for (int i = 0; i < 8; i++) exp_d.push_back(ev(i, hex_tab[i], 1'b0));
    enable_frame(32'h1);
    check_lit("bright3", 8'hFF, 4);
    disable_disp();
    wr(4'h8, 32'h0, 4'hF, 1'b1);
    for (int i = 0; i < 8; i++) exp_d.push_back(ev(i, hex_tab[i], 1'b0));
    enable_frame(32'h1);
    check_lit("bright0", 8'hFF, 1);

    // Reserved bits read back as zero
    disable_disp();
    wr(4'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(4'h4, 32'h00FF_FF03, 32'hFFFF_FFFF, "ctrl_rsvd");
    disable_disp();
    wr(4'h8, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(4'h8, 32'hF, 32'hFFFF_FFFF, "bright_rsvd");
    drain_axi();

    // Reset while scanning with a B response pending
    wr(4'h4, 32'h1, 4'hF, 1'b1);
    drain_axi();
    repeat (40) @(negedge clk);
    #1 bready = 1'b0;
    wr(4'h0, 32'h1234_5678, 4'hF, 1'b0);
    repeat (3) @(negedge clk);
    check("b_pending", {31'h0, bvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_an", {24'h0, an}, 32'hFF);
    check("arst_seg", {25'h0, seg}, 32'h7F);
    check("arst_dp", {31'h0, dp}, 32'h1);
    check("arst_bvalid", {31'h0, bvalid}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 bready = 1'b1;
    repeat (20) @(negedge clk);
    rd(4'h0, 32'h0, 32'hFFFF_FFFF, "arst_data");
    rd(4'h4, 32'h0, 32'hFFFF_FFFF, "arst_ctrl");
    rd(4'h8, 32'hF, 32'hFFFF_FFFF, "arst_bright");

    // Byte strobes and read-only STATUS
    wr(4'h0, 32'h7654_3210, 4'hF, 1'b1);
    wr(4'h0, 32'hAAAA_AAAA, 4'b0010, 1'b1);
    rd(4'h0, 32'h7654_AA10, 32'hFFFF_FFFF, "wstrb_data");
    wr(4'hC, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(4'hC, 32'h0, 32'hFFFF_FFFF, "status_ro");
    drain_axi();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
